// File: rtl/scc_pkg.sv
// Shared types for the SCC control sequencer: FSM states, opcode encodings,
// instruction classes and trap cause codes.
package scc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM    = 4'd4,
        ST_WB     = 4'd5,
        ST_HALTED = 4'd6,
        ST_TRAP   = 4'd7,
        ST_PAUSE  = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_REG     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_NOP     = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_HALT    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_t;

    localparam logic [6:0] OP_LOAD  = 7'b1000000;
    localparam logic [6:0] OP_STORE = 7'b1000001;
    localparam logic [6:0] OP_NOP   = 7'b1100100;
    localparam logic [6:0] OP_HALT  = 7'b1101000;
    // Branches occupy 11000xx except 1100011.
    localparam logic [4:0] OP_BRANCH_HI = 5'b11000;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

endpackage

// File: rtl/scc_op_classify.sv
// Purpose: classify a 7-bit opcode into an instruction class and flag-update bit.
// Latency: combinational. Backpressure: none.
// Config: not affected by SCC_SINGLE_STEP_EN.
module scc_op_classify
    import scc_pkg::*;
(
    input  logic [6:0] opcode_i,
    output op_class_t  op_class_o,
    output logic       sets_flags_o
);

    always_comb begin
        op_class_o = CLS_ILLEGAL;
        if (opcode_i[6] == 1'b0) begin
            op_class_o = CLS_REG;
        end else if (opcode_i == OP_LOAD) begin
            op_class_o = CLS_LOAD;
        end else if (opcode_i == OP_STORE) begin
            op_class_o = CLS_STORE;
        end else if (opcode_i == OP_NOP) begin
            op_class_o = CLS_NOP;
        end else if (opcode_i == OP_HALT) begin
            op_class_o = CLS_HALT;
        end else if (opcode_i[6:2] == OP_BRANCH_HI && opcode_i[1:0] != 2'b11) begin
            op_class_o = CLS_BRANCH;
        end
    end

    assign sets_flags_o = (opcode_i[6] == 1'b0) && opcode_i[3];

endmodule

// File: rtl/scc_control_sequencer.sv
// Purpose: multi-cycle IF->ID->ALU/DMEM->WB control FSM with halt/trap status and retire count.
// Latency: REG 4, NOP/BRANCH 3, LOAD/STORE 5 + dmem wait cycles; FETCH stalls on instr_valid, MEM on dmem_ready.
// Config: SCC_SINGLE_STEP_EN adds step_mode/step_req and a PAUSE state after each WB.
module scc_control_sequencer
    import scc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RETIRE_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                instr_valid,
    input  logic [6:0]          opcode,
    input  logic                dmem_ready,
`ifdef SCC_SINGLE_STEP_EN
    input  logic                step_mode,
    input  logic                step_req,
`endif
    output logic                ir_load,
    output logic                alu_en,
    output logic                dmem_re,
    output logic                dmem_we,
    output logic                rf_we,
    output logic                flags_we,
    output logic                pc_en,
    output logic                halted,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [RETIRE_W-1:0] retired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [6:0]          opcode_q, opcode_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic [1:0]          cause_q, cause_d;

    op_class_t op_class;
    logic      sets_flags;

    scc_op_classify u_classify (
        .opcode_i     (opcode_q),
        .op_class_o   (op_class),
        .sets_flags_o (sets_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            cnt_q     <= '0;
            retired_q <= '0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        cnt_d     = cnt_q;
        retired_d = retired_q;
        cause_d   = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    opcode_d = opcode;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (op_class)
                    CLS_HALT:    state_d = ST_HALTED;
                    CLS_ILLEGAL: begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                    CLS_NOP, CLS_BRANCH: state_d = ST_WB;
                    default:     state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (op_class == CLS_LOAD || op_class == CLS_STORE) begin
                    state_d = ST_MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                // A ready arriving on the final allowed cycle still completes the access.
                if (dmem_ready) begin
                    state_d = ST_WB;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                retired_d = retired_q + RETIRE_W'(1);
`ifdef SCC_SINGLE_STEP_EN
                state_d   = step_mode ? ST_PAUSE : ST_FETCH;
`else
                state_d   = ST_FETCH;
`endif
            end
            ST_PAUSE: begin
`ifdef SCC_SINGLE_STEP_EN
                if (step_req) state_d = ST_FETCH;
`else
                state_d = ST_FETCH;
`endif
            end
            ST_HALTED, ST_TRAP: state_d = state_q;
            default:            state_d = ST_IDLE;
        endcase
    end

    // Moore strobes from registered state and latched opcode; only ir_load looks at an input.
    assign ir_load    = (state_q == ST_FETCH) && instr_valid;
    assign alu_en     = (state_q == ST_EXEC);
    assign dmem_re    = (state_q == ST_MEM) && (op_class == CLS_LOAD);
    assign dmem_we    = (state_q == ST_MEM) && (op_class == CLS_STORE);
    assign rf_we      = (state_q == ST_WB) && (op_class == CLS_REG || op_class == CLS_LOAD);
    assign flags_we   = (state_q == ST_WB) && (op_class == CLS_REG) && sets_flags;
    assign pc_en      = (state_q == ST_WB);
    assign halted     = (state_q == ST_HALTED);
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule
